// File: rtl/mem_block_server_pkg.sv
// ============================================================================
// Module   : mem_block_server_pkg
// Brief    : Shared types and constants for the block-read memory server.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

package mem_block_server_pkg;

    localparam int unsigned c_block_words       = 4;
    localparam int unsigned c_addr_width        = 32;
    localparam int unsigned c_block_offset_bits = $clog2(c_block_words * 4);

    // One cache block: word k sits at index k
    typedef logic [c_block_words-1:0][31:0] block_t;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ISSUE = 2'd1,
        ST_WAIT  = 2'd2,
        ST_DONE  = 2'd3
    } srv_state_t;

    typedef struct packed {
        logic                    valid;
        logic [c_addr_width-1:0] addr;
    } mem_word_req_t;

    typedef struct packed {
        logic        valid;
        logic [31:0] data;
    } mem_word_rsp_t;

    // Byte-offset bits inside a block of the given word count
    function automatic int unsigned block_offset_bits(input int unsigned words);
        return $clog2(words * 4);
    endfunction

endpackage

`default_nettype wire

// File: rtl/mem_block_server_rr_arbiter.sv
// ============================================================================
// Module   : mem_block_server_rr_arbiter
// Brief    : Combinational round-robin pick: first set request at or after
//            ptr, wrapping modulo N.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module mem_block_server_rr_arbiter #(
    parameter int unsigned N     = 2,
    parameter int unsigned IDX_W = (N > 1) ? $clog2(N) : 1
) (
    input  logic [N-1:0]     req,
    input  logic [IDX_W-1:0] ptr,
    output logic [IDX_W-1:0] grant_idx,
    output logic             grant_valid
);

    // Scan N positions starting at ptr; the first hit wins
    always_comb begin
        grant_valid = 1'b0;
        grant_idx   = '0;
        for (int i = 0; i < N; i++) begin
            int unsigned      j;
            logic [IDX_W-1:0] jj;
            j  = (32'(ptr) + 32'(i)) % N;
            jj = IDX_W'(j);
            if (!grant_valid && req[jj]) begin
                grant_valid = 1'b1;
                grant_idx   = jj;
            end
        end
    end

endmodule

`default_nettype wire

// File: rtl/mem_block_server.sv
// ============================================================================
// Module   : mem_block_server
// Brief    : Serves block reads from PORT_CNT initiators as BLOCK_WORDS
//            sequential word reads on one downstream port, round-robin.
//            Optional macro MEM_BLOCK_SERVER_STATS_EN adds served_cnt and
//            busy_cycles saturating counters.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module mem_block_server
    import mem_block_server_pkg::*;
#(
    parameter int unsigned PORT_CNT    = 2,
    parameter int unsigned BLOCK_WORDS = 4,
    parameter int unsigned ADDR_WIDTH  = 32
) (
    input  logic                                clk,
    input  logic                                rst,
    input  logic                                en,
    input  logic [PORT_CNT-1:0]                 req_valid,
    input  logic [PORT_CNT-1:0][ADDR_WIDTH-1:0] req_addr,
    output logic [PORT_CNT-1:0]                 rsp_valid,
    output logic [BLOCK_WORDS-1:0][31:0]        rsp_data,
    output logic                                mem_req_valid,
    output logic [ADDR_WIDTH-1:0]               mem_req_addr,
    input  logic                                mem_req_rdy,
    input  logic                                mem_rsp_valid,
    input  logic [31:0]                         mem_rsp_data
`ifdef MEM_BLOCK_SERVER_STATS_EN
    ,
    output logic [PORT_CNT-1:0][31:0]           served_cnt,
    output logic [31:0]                         busy_cycles
`endif
);

    localparam int unsigned c_idx_w    = (PORT_CNT > 1) ? $clog2(PORT_CNT) : 1;
    localparam int unsigned c_k_w      = $clog2(BLOCK_WORDS);
    localparam int unsigned c_off_bits = block_offset_bits(BLOCK_WORDS);
    localparam logic [ADDR_WIDTH-1:0] c_off_mask =
        ADDR_WIDTH'((64'd1 << c_off_bits) - 64'd1);

    srv_state_t                    state_q, state_d;
    logic [c_idx_w-1:0]            port_q, port_d;
    logic [c_idx_w-1:0]            rr_ptr_q, rr_ptr_d;
    logic [ADDR_WIDTH-1:0]         base_q, base_d;
    logic [c_k_w-1:0]              k_q, k_d;
    logic [BLOCK_WORDS-1:0][31:0]  buf_q, buf_d;
    logic [PORT_CNT-1:0]           rsp_valid_q, rsp_valid_d;
    logic [BLOCK_WORDS-1:0][31:0]  rsp_data_q, rsp_data_d;

    logic [c_idx_w-1:0]            w_grant_idx;
    logic                          w_grant_valid;
    logic [ADDR_WIDTH-1:0]         w_sel_addr;
    logic [ADDR_WIDTH-1:0]         w_aligned;
    logic [ADDR_WIDTH-1:0]         w_word_off;

    mem_block_server_rr_arbiter #(
        .N     (PORT_CNT),
        .IDX_W (c_idx_w)
    ) u_arb (
        .req         (req_valid),
        .ptr         (rr_ptr_q),
        .grant_idx   (w_grant_idx),
        .grant_valid (w_grant_valid)
    );

    assign w_sel_addr    = req_addr[w_grant_idx];
    assign w_aligned     = w_sel_addr & ~c_off_mask;
    assign w_word_off    = ADDR_WIDTH'({k_q, 2'b00});
    assign mem_req_valid = (state_q == ST_ISSUE);
    assign mem_req_addr  = base_q + w_word_off;
    assign rsp_valid     = rsp_valid_q;
    assign rsp_data      = rsp_data_q;

    // Next-state logic: arbitrate, issue one word, wait for it, repeat, return
    always_comb begin
        state_d     = state_q;
        port_d      = port_q;
        rr_ptr_d    = rr_ptr_q;
        base_d      = base_q;
        k_d         = k_q;
        buf_d       = buf_q;
        rsp_valid_d = '0;
        rsp_data_d  = rsp_data_q;
        case (state_q)
            ST_IDLE: begin
                if (w_grant_valid) begin
                    port_d  = w_grant_idx;
                    base_d  = w_aligned;
                    k_d     = '0;
                    state_d = ST_ISSUE;
                end
            end
            ST_ISSUE: begin
                if (mem_req_rdy) begin
                    state_d = ST_WAIT;
                end
            end
            ST_WAIT: begin
                if (mem_rsp_valid) begin
                    buf_d[k_q] = mem_rsp_data;
                    if (k_q == c_k_w'(BLOCK_WORDS - 1)) begin
                        state_d = ST_DONE;
                    end else begin
                        k_d     = k_q + c_k_w'(1);
                        state_d = ST_ISSUE;
                    end
                end
            end
            ST_DONE: begin
                rsp_valid_d[port_q] = 1'b1;
                rsp_data_d          = buf_q;
                rr_ptr_d            = (port_q == c_idx_w'(PORT_CNT - 1)) ?
                                      '0 : port_q + c_idx_w'(1);
                k_d                 = '0;
                state_d             = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // State registers; en low freezes everything, reset drops partial blocks
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= ST_IDLE;
            port_q      <= '0;
            rr_ptr_q    <= '0;
            base_q      <= '0;
            k_q         <= '0;
            buf_q       <= '0;
            rsp_valid_q <= '0;
            rsp_data_q  <= '0;
        end else if (en) begin
            state_q     <= state_d;
            port_q      <= port_d;
            rr_ptr_q    <= rr_ptr_d;
            base_q      <= base_d;
            k_q         <= k_d;
            buf_q       <= buf_d;
            rsp_valid_q <= rsp_valid_d;
            rsp_data_q  <= rsp_data_d;
        end
    end

`ifdef MEM_BLOCK_SERVER_STATS_EN
    logic [PORT_CNT-1:0][31:0] served_cnt_q, served_cnt_d;
    logic [31:0]               busy_q, busy_d;

    // Saturating per-port service counts and non-idle cycle count
    always_comb begin
        served_cnt_d = served_cnt_q;
        busy_d       = busy_q;
        for (int i = 0; i < PORT_CNT; i++) begin
            if (rsp_valid_d[i] && (served_cnt_q[i] != 32'hFFFF_FFFF)) begin
                served_cnt_d[i] = served_cnt_q[i] + 32'd1;
            end
        end
        if ((state_q != ST_IDLE) && (busy_q != 32'hFFFF_FFFF)) begin
            busy_d = busy_q + 32'd1;
        end
    end

    // Counter registers, advanced only in enabled cycles
    always_ff @(posedge clk) begin
        if (rst) begin
            served_cnt_q <= '0;
            busy_q       <= '0;
        end else if (en) begin
            served_cnt_q <= served_cnt_d;
            busy_q       <= busy_d;
        end
    end

    assign served_cnt  = served_cnt_q;
    assign busy_cycles = busy_q;
`endif

endmodule

`default_nettype wire

// File: doc/mem_block_server.md
Name: mem_block_server

Overview:
- Memory-side responder for the instruction cache's block-read ports.
- Accepts block-read requests on port_cnt initiator ports and arbitrates them round-robin.
- Serves each block as block_words sequential word reads over a single downstream word-read port, then assembles and returns the block on the winning port.
- Sits between inst_cache and a single-ported word memory; replaces the multi-ported block path.

Parameters:
- port_cnt, 2, number of block-read initiator ports (1..8).
- block_words, 4, 32-bit words per block; power of two, 2..16.
- addr_width, 32, byte address width.

Ports:
- clk  in  1  global clock.
- rst  in  1  synchronous active-high reset.
- en  in  1  global enable; when low all state holds.
- req_valid  in  [port_cnt]  block request pending per port.
- req_addr  in  [port_cnt][addr_width]  block byte address per port; low log2(block_words*4) bits ignored.
- rsp_valid  out  [port_cnt]  one-cycle pulse, block returned on that port.
- rsp_data  out  [block_words][32]  assembled block, shared by all ports, qualified by rsp_valid.
- mem_req_valid  out  1  downstream word read request.
- mem_req_addr  out  addr_width  downstream word byte address, 4-byte aligned.
- mem_req_rdy  in  1  downstream accepts the request this cycle.
- mem_rsp_valid  in  1  downstream read data valid.
- mem_rsp_data  in  32  downstream read data.

Behaviour:
- Reset values: rsp_valid all 0, rsp_data 0, mem_req_valid 0, mem_req_addr 0, rr_ptr 0, word counter 0, state IDLE.
- FSM states: IDLE, ISSUE, WAIT, DONE.
- IDLE:
  - If any req_valid is set, pick the first set port at or after rr_ptr, wrapping modulo port_cnt.
  - Latch the port index and the aligned base address; go to ISSUE.
- ISSUE:
  - mem_req_valid=1 and mem_req_addr=base+4*k, where k is the word counter.
  - On mem_req_rdy, go to WAIT. mem_req_valid drops the same cycle the FSM leaves ISSUE.
- WAIT:
  - On mem_rsp_valid, write mem_rsp_data into word k of the block buffer.
  - If k==block_words-1, go to DONE; otherwise k+=1 and go to ISSUE.
  - A mem_rsp_valid arriving in the same cycle as mem_req_rdy is not legal downstream; a response needs at least 1 cycle of latency.
- DONE:
  - rsp_valid[port]=1 for exactly one cycle, and rsp_data holds the buffer.
  - rr_ptr = (port+1) mod port_cnt; k=0; go to IDLE.
- rsp_data holds its value until the next DONE.
- Latency: minimum 2*block_words+2 cycles from IDLE accept to rsp_valid, with a 1-cycle mem_req_rdy and 1-cycle memory.
- Back-to-back requests: a new arbitration happens in the cycle after DONE. A port whose req_valid stays high is re-served only after the other pending ports, under round-robin.
- Initiator rule: hold req_valid and req_addr stable until rsp_valid. If req_valid drops mid-service, the block still completes and pulses rsp_valid; the initiator ignores it.
- Address is latched at accept; later req_addr changes have no effect on the block in flight.
- Address arithmetic: base+4*k uses modulo 2^addr_width wrap; word offsets never cross the block boundary.
- en low: FSM, counters and outputs freeze. mem_rsp_valid arriving while en is low is lost; the downstream is required to share en.
- rst mid-operation: return to IDLE next cycle and discard the partial buffer. A stale mem_rsp_valid received in IDLE or ISSUE is dropped.

Optional Feature:
- Macro MEM_BLOCK_SERVER_STATS_EN.
- Defined:
  - Adds output served_cnt [port_cnt][32], which increments on each rsp_valid for that port.
  - Adds output busy_cycles [32], which increments every enabled cycle the state is not IDLE.
  - Both saturate at 2^32-1 and reset to 0.
- Undefined: neither port exists and no counter logic is built.

Decomposition:
- Shared package (sys):
  - block_t typedef (array of block_words 32-bit words).
  - mem_block_server state enum.
  - Word-read req/rsp struct typedefs (mem_word_req_t, mem_word_rsp_t).
  - block_offset_bits constant.
- One sub-module: rr_arbiter (port_cnt requests, ptr in, grant index plus valid out), purely combinational and reusable by the data-side arbiter.

Test Plan:
- Single request: port0 addr 0x100, memory words 0x11,0x22,0x33,0x44 with 1-cycle latency -> rsp_valid[0] at cycle 10, rsp_data={0x11,0x22,0x33,0x44}, downstream addresses 0x100,0x104,0x108,0x10C.
- Simultaneous requests: ports 0 and 1 both valid with rr_ptr=0 -> port0 served first, then port1. Repeating with both held -> the order alternates 0,1,0,1.
- Unaligned address 0x10A -> base 0x100, reads 0x100..0x10C.
- Backpressure: mem_req_rdy low for 3 cycles on word 2 -> mem_req_addr holds 0x108 and latency grows by 3.
- Reset in WAIT after word 1, then a stale mem_rsp_valid -> no rsp_valid; the next request returns correct data.
- STATS_EN: 3 blocks served on port1 -> served_cnt[1]=3, and busy_cycles equals the summed non-IDLE cycles.
